count_monitor: RTL and testbench

- Checker for the up/down counter's output stream: the consuming end of the counter's `out` and `up` interface.
- Samples the observed count and direction each enabled cycle, then predicts the next value (±1, modulo 2^WIDTH, or 0 on clear).
- Locks onto a valid sequence and flags every deviation.
- Used in-system and in benches as a self-checking receiver for counter instances.

---
 rtl/count_monitor_pkg.sv | 18 +
 rtl/sat_counter.sv | 36 +++
 rtl/count_monitor.sv | 172 +++++++++++++++++
 tb/tb_count_monitor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: shared types and defaults for the counter output monitor.
//   state_e      : monitor FSM state (2-bit encoding)
//   DEF_*        : default parameter values for count_monitor
//   MATCH_W      : width of the consecutive-match counter (SYNC_LEN up to 15)
package count_monitor_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_SYNC_LEN = 2;
  localparam int DEF_ERR_W    = 8;
  localparam int MATCH_W      = 4;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears q
//   inc   : increment request (ignored once saturated)
//   q     : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/count_monitor.sv
// count_monitor: self-checking receiver for an up/down counter's out/up stream.
// Predicts the next sample (+1 / -1 modulo 2^WIDTH, or 0 after a clear), locks
// after SYNC_LEN consecutive correct predictions and flags every mismatch
// seen while locked.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   cnt_valid           : sample strobe; cnt_in/up_in/cnt_clr used only when 1
//   cnt_in, up_in       : observed count and direction of this sample
//   cnt_clr             : observed counter was cleared at this sample
//   locked              : FSM is in ST_LOCKED
//   err_pulse           : one-cycle pulse, the cycle after a locked mismatch
//   err_count           : saturating count of locked mismatches
//   expected            : predicted value of the next valid sample
// Optional (macro COUNT_MONITOR_ERR_LOG_EN):
//   first_err_exp/obs/vld : expected/observed values at the first locked
//                           mismatch after reset; held until reset.
//
// Handshake: cnt_valid is a one-way strobe with no ready; the monitor accepts
// a sample on every rising edge where cnt_valid is 1 and holds all state
// otherwise.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SYNC_LEN = DEF_SYNC_LEN,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_valid,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             up_in,
  input  logic             cnt_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
`ifdef COUNT_MONITOR_ERR_LOG_EN
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_obs,
  output logic             first_err_vld,
`endif
  output logic [WIDTH-1:0] expected
);

  localparam logic [MATCH_W-1:0] SYNC_TGT = MATCH_W'(SYNC_LEN);

  state_e             state_q, state_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [MATCH_W-1:0] match_cnt_inc;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic               err_pulse_q, err_pulse_d;
  logic [WIDTH-1:0]   nxt;
  logic               hit;
  logic               err_inc;

  always_comb begin
    // Wrap-around is natural WIDTH-bit arithmetic, never an error.
    if (cnt_clr) begin
      nxt = '0;
    end else if (up_in) begin
      nxt = cnt_in + 1'b1;
    end else begin
      nxt = cnt_in - 1'b1;
    end
    hit           = (cnt_in == expected_q);
    match_cnt_inc = match_cnt_q + 1'b1;

    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    expected_d  = expected_q;
    err_inc     = 1'b0;

    if (cnt_valid) begin
      // Every valid sample re-seeds the prediction, matching or not.
      expected_d = nxt;
      case (state_q)
        ST_UNLOCKED: begin
          state_d     = ST_SYNC;
          match_cnt_d = '0;
        end
        ST_SYNC: begin
          if (hit) begin
            if (match_cnt_inc == SYNC_TGT) begin
              state_d     = ST_LOCKED;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_inc;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!hit) begin
            err_inc     = 1'b1;
            state_d     = ST_SYNC;
            match_cnt_d = '0;
          end
        end
        default: begin
          state_d     = ST_UNLOCKED;
          match_cnt_d = '0;
        end
      endcase
    end

    // A mismatch always leaves ST_LOCKED, so this can never stay high twice.
    err_pulse_d = err_inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_UNLOCKED;
      match_cnt_q <= '0;
      expected_q  <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      expected_q  <= expected_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (err_inc),
    .q    (err_count)
  );

`ifdef COUNT_MONITOR_ERR_LOG_EN
  logic [WIDTH-1:0] first_err_exp_q, first_err_exp_d;
  logic [WIDTH-1:0] first_err_obs_q, first_err_obs_d;
  logic             first_err_vld_q, first_err_vld_d;

  always_comb begin
    first_err_exp_d = first_err_exp_q;
    first_err_obs_d = first_err_obs_q;
    first_err_vld_d = first_err_vld_q;
    // Only the first locked mismatch after reset is logged.
    if (err_inc && !first_err_vld_q) begin
      first_err_exp_d = expected_q;
      first_err_obs_d = cnt_in;
      first_err_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_err_exp_q <= '0;
      first_err_obs_q <= '0;
      first_err_vld_q <= 1'b0;
    end else begin
      first_err_exp_q <= first_err_exp_d;
      first_err_obs_q <= first_err_obs_d;
      first_err_vld_q <= first_err_vld_d;
    end
  end

  assign first_err_exp = first_err_exp_q;
  assign first_err_obs = first_err_obs_q;
  assign first_err_vld = first_err_vld_q;
`endif

  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = err_pulse_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: directed bench for count_monitor. Two instances share the
// stimulus: dut (default ERR_W = 8) and dut_w2 (ERR_W = 2, for saturation).
// Inputs change on the falling edge; outputs are checked 1 time unit after
// the rising edge. Optional log ports are covered when
// COUNT_MONITOR_ERR_LOG_EN is defined.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cnt_valid = 1'b0;
  logic [3:0] cnt_in = 4'd0;
  logic       up_in = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       locked, err_pulse;
  logic [7:0] err_count;
  logic [3:0] expected;
  logic       locked2, err_pulse2;
  logic [1:0] err_count2;
  logic [3:0] expected2;
`ifdef COUNT_MONITOR_ERR_LOG_EN
  logic [3:0] first_err_exp, first_err_obs, first_err_exp2, first_err_obs2;
  logic       first_err_vld, first_err_vld2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  count_monitor #(.WIDTH(4), .SYNC_LEN(2), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .cnt_valid(cnt_valid), .cnt_in(cnt_in),
    .up_in(up_in), .cnt_clr(cnt_clr), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count),
`ifdef COUNT_MONITOR_ERR_LOG_EN
    .first_err_exp(first_err_exp), .first_err_obs(first_err_obs),
    .first_err_vld(first_err_vld),
`endif
    .expected(expected)
  );

  count_monitor #(.WIDTH(4), .SYNC_LEN(2), .ERR_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .cnt_valid(cnt_valid), .cnt_in(cnt_in),
    .up_in(up_in), .cnt_clr(cnt_clr), .locked(locked2), .err_pulse(err_pulse2),
    .err_count(err_count2),
`ifdef COUNT_MONITOR_ERR_LOG_EN
    .first_err_exp(first_err_exp2), .first_err_obs(first_err_obs2),
    .first_err_vld(first_err_vld2),
`endif
    .expected(expected2)
  );

  // ---------------- driver tasks ----------------
  task automatic sample(input logic [3:0] v, input logic u, input logic c);
    @(negedge clk);
    cnt_valid = 1'b1;
    cnt_in    = v;
    up_in     = u;
    cnt_clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] junk);
    @(negedge clk);
    cnt_valid = 1'b0;
    cnt_in    = junk;
    up_in     = 1'b0;
    cnt_clr   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    cnt_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Checks dut's four outputs against hand-computed values.
  // (Each test writes its own comparisons inline.)

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %0b want 0", locked); end
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_err_pulse: got %0b want 0", err_pulse); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
    n_checks++; if (expected !== 4'd0) begin n_fail++; $display("FAIL rst_expected: got %0d want 0", expected); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_lock_up();
    sample(4'd0, 1'b1, 1'b0);
    n_checks++; if (expected !== 4'd1 || locked !== 1'b0) begin n_fail++; $display("FAIL lock_s0: exp=%0d locked=%0b want 1/0", expected, locked); end
    sample(4'd1, 1'b1, 1'b0);
    n_checks++; if (expected !== 4'd2 || locked !== 1'b0) begin n_fail++; $display("FAIL lock_s1: exp=%0d locked=%0b want 2/0", expected, locked); end
    sample(4'd2, 1'b1, 1'b0);
    n_checks++; if (expected !== 4'd3 || locked !== 1'b1) begin n_fail++; $display("FAIL lock_s2: exp=%0d locked=%0b want 3/1", expected, locked); end
    sample(4'd3, 1'b1, 1'b0);
    n_checks++; if (expected !== 4'd4 || locked !== 1'b1) begin n_fail++; $display("FAIL lock_s3: exp=%0d locked=%0b want 4/1", expected, locked); end
    sample(4'd4, 1'b1, 1'b0);
    n_checks++; if (expected !== 4'd5 || err_count !== 8'd0) begin n_fail++; $display("FAIL lock_s4: exp=%0d errs=%0d want 5/0", expected, err_count); end
  endtask

  task automatic test_hold();
    idle(4'd9);
    idle(4'd2);
    n_checks++; if (expected !== 4'd5 || locked !== 1'b1 || err_pulse !== 1'b0) begin
      n_fail++; $display("FAIL hold: exp=%0d locked=%0b pulse=%0b want 5/1/0", expected, locked, err_pulse);
    end
  endtask

  task automatic test_wrap();
    for (int k = 5; k <= 15; k++) sample(4'(k), 1'b1, 1'b0);
    n_checks++; if (expected !== 4'd0 || locked !== 1'b1) begin n_fail++; $display("FAIL wrap_up15: exp=%0d locked=%0b want 0/1", expected, locked); end
    sample(4'd0, 1'b0, 1'b0);
    n_checks++; if (expected !== 4'd15 || locked !== 1'b1 || err_count !== 8'd0) begin
      n_fail++; $display("FAIL wrap_0: exp=%0d locked=%0b errs=%0d want 15/1/0", expected, locked, err_count);
    end
    sample(4'd15, 1'b0, 1'b0);
    sample(4'd14, 1'b0, 1'b0);
    n_checks++; if (expected !== 4'd13 || locked !== 1'b1 || err_count !== 8'd0) begin
      n_fail++; $display("FAIL wrap_down: exp=%0d locked=%0b errs=%0d want 13/1/0", expected, locked, err_count);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    sample(4'd3, 1'b1, 1'b0);
    sample(4'd4, 1'b1, 1'b0);
    sample(4'd5, 1'b1, 1'b0);
    n_checks++; if (expected !== 4'd6 || locked !== 1'b1) begin n_fail++; $display("FAIL mm_pre: exp=%0d locked=%0b want 6/1", expected, locked); end
    sample(4'd9, 1'b1, 1'b0);
    n_checks++; if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || expected !== 4'd10) begin
      n_fail++; $display("FAIL mm_hit: pulse=%0b errs=%0d locked=%0b exp=%0d want 1/1/0/10", err_pulse, err_count, locked, expected);
    end
    sample(4'd10, 1'b1, 1'b0);
    n_checks++; if (err_pulse !== 1'b0 || locked !== 1'b0) begin n_fail++; $display("FAIL mm_after: pulse=%0b locked=%0b want 0/0", err_pulse, locked); end
    sample(4'd11, 1'b1, 1'b0);
    n_checks++; if (locked !== 1'b1 || err_count !== 8'd1 || expected !== 4'd12) begin
      n_fail++; $display("FAIL mm_relock: locked=%0b errs=%0d exp=%0d want 1/1/12", locked, err_count, expected);
    end
  endtask

  task automatic test_clear();
    do_reset();
    sample(4'd4, 1'b1, 1'b0);
    sample(4'd5, 1'b1, 1'b0);
    sample(4'd6, 1'b1, 1'b0);
    sample(4'd7, 1'b1, 1'b1);
    n_checks++; if (expected !== 4'd0 || locked !== 1'b1) begin n_fail++; $display("FAIL clr_pred: exp=%0d locked=%0b want 0/1", expected, locked); end
    sample(4'd0, 1'b1, 1'b0);
    n_checks++; if (err_pulse !== 1'b0 || locked !== 1'b1 || err_count !== 8'd0 || expected !== 4'd1) begin
      n_fail++; $display("FAIL clr_match: pulse=%0b locked=%0b errs=%0d exp=%0d want 0/1/0/1", err_pulse, locked, err_count, expected);
    end
    for (int k = 1; k <= 6; k++) sample(4'(k), 1'b1, 1'b0);
    sample(4'd7, 1'b1, 1'b1);
    sample(4'd8, 1'b1, 1'b0);
    n_checks++; if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || expected !== 4'd9) begin
      n_fail++; $display("FAIL clr_err: pulse=%0b errs=%0d locked=%0b exp=%0d want 1/1/0/9", err_pulse, err_count, locked, expected);
    end
    sample(4'd9, 1'b1, 1'b0);
    sample(4'd10, 1'b1, 1'b0);
    // Mismatching sample that also carries a clear: still an error.
    sample(4'd3, 1'b1, 1'b1);
    n_checks++; if (err_pulse !== 1'b1 || err_count !== 8'd2 || expected !== 4'd0) begin
      n_fail++; $display("FAIL clr_own_mm: pulse=%0b errs=%0d exp=%0d want 1/2/0", err_pulse, err_count, expected);
    end
    sample(4'd0, 1'b1, 1'b0);
    n_checks++; if (err_pulse !== 1'b0 || err_count !== 8'd2) begin n_fail++; $display("FAIL clr_own_after: pulse=%0b errs=%0d want 0/2", err_pulse, err_count); end
  endtask

  task automatic test_saturation();
    logic [3:0] e, v;
    int pulses;
    pulses = 0;
    do_reset();
    sample(4'd0, 1'b1, 1'b0);
    sample(4'd1, 1'b1, 1'b0);
    sample(4'd2, 1'b1, 1'b0);
    e = 4'd3;
    n_checks++; if (locked2 !== 1'b1) begin n_fail++; $display("FAIL sat_lock: locked=%0b want 1", locked2); end
    for (int i = 0; i < 5; i++) begin
      v = e + 4'd5;
      sample(v, 1'b1, 1'b0);
      if (err_pulse2 === 1'b1) pulses++;
      n_checks++; if (err_count2 !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin
        n_fail++; $display("FAIL sat_cnt%0d: errs=%0d want %0d", i, err_count2, (i < 3) ? i + 1 : 3);
      end
      sample(v + 4'd1, 1'b1, 1'b0);
      if (err_pulse2 === 1'b1) pulses++;
      sample(v + 4'd2, 1'b1, 1'b0);
      if (err_pulse2 === 1'b1) pulses++;
      n_checks++; if (locked2 !== 1'b1) begin n_fail++; $display("FAIL sat_relock%0d: locked=%0b want 1", i, locked2); end
      e = v + 4'd3;
    end
    n_checks++; if (pulses != 5) begin n_fail++; $display("FAIL sat_pulses: got %0d want 5", pulses); end
    // Asynchronous reset in the middle of a clock phase.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (locked2 !== 1'b0 || err_pulse2 !== 1'b0 || err_count2 !== 2'd0 || expected2 !== 4'd0) begin
      n_fail++; $display("FAIL async_rst_w2: locked=%0b pulse=%0b errs=%0d exp=%0d want 0/0/0/0", locked2, err_pulse2, err_count2, expected2);
    end
    n_checks++; if (locked !== 1'b0 || err_count !== 8'd0 || expected !== 4'd0) begin
      n_fail++; $display("FAIL async_rst: locked=%0b errs=%0d exp=%0d want 0/0/0", locked, err_count, expected);
    end
    @(negedge clk);
    cnt_valid = 1'b0;
    reset     = 1'b1;
    // Expected is 0 here, so a locked-state bug would flag sample 9.
    sample(4'd9, 1'b1, 1'b0);
    n_checks++; if (locked2 !== 1'b0 || expected2 !== 4'd10 || err_count2 !== 2'd0) begin
      n_fail++; $display("FAIL post_rst: locked=%0b exp=%0d errs=%0d want 0/10/0", locked2, expected2, err_count2);
    end
    sample(4'd10, 1'b1, 1'b0);
    n_checks++; if (err_pulse2 !== 1'b0 || locked2 !== 1'b0) begin n_fail++; $display("FAIL post_rst_sync: pulse=%0b locked=%0b want 0/0", err_pulse2, locked2); end
  endtask

`ifdef COUNT_MONITOR_ERR_LOG_EN
  task automatic test_err_log();
    do_reset();
    n_checks++; if (first_err_vld !== 1'b0 || first_err_exp !== 4'd0 || first_err_obs !== 4'd0) begin
      n_fail++; $display("FAIL log_rst: vld=%0b exp=%0d obs=%0d want 0/0/0", first_err_vld, first_err_exp, first_err_obs);
    end
    sample(4'd3, 1'b1, 1'b0);
    sample(4'd4, 1'b1, 1'b0);
    sample(4'd5, 1'b1, 1'b0);
    sample(4'd9, 1'b1, 1'b0);
    n_checks++; if (first_err_vld !== 1'b1 || first_err_exp !== 4'd6 || first_err_obs !== 4'd9) begin
      n_fail++; $display("FAIL log_first: vld=%0b exp=%0d obs=%0d want 1/6/9", first_err_vld, first_err_exp, first_err_obs);
    end
    sample(4'd10, 1'b1, 1'b0);
    sample(4'd11, 1'b1, 1'b0);
    for (int k = 12; k <= 18; k++) sample(4'(k), 1'b1, 1'b0);
    n_checks++; if (expected !== 4'd3 || locked !== 1'b1) begin n_fail++; $display("FAIL log_pre2: exp=%0d locked=%0b want 3/1", expected, locked); end
    sample(4'd1, 1'b1, 1'b0);
    n_checks++; if (err_pulse !== 1'b1 || err_count !== 8'd2) begin n_fail++; $display("FAIL log_err2: pulse=%0b errs=%0d want 1/2", err_pulse, err_count); end
    n_checks++; if (first_err_vld !== 1'b1 || first_err_exp !== 4'd6 || first_err_obs !== 4'd9) begin
      n_fail++; $display("FAIL log_hold: vld=%0b exp=%0d obs=%0d want 1/6/9", first_err_vld, first_err_exp, first_err_obs);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock_up();
    test_hold();
    test_wrap();
    test_mismatch();
    test_clear();
    test_saturation();
`ifdef COUNT_MONITOR_ERR_LOG_EN
    test_err_log();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
